// File: rtl/clk_burst_if.sv
// clk_burst_if: control/status bundle for clk_burst_gen.
//   master modport: the controller side. It drives start/stop/half_period/num_edges
//                   and observes the generated clock and its status.
//   slave modport : the generator side (clk_burst_gen).
//   Signals:
//     start, stop          run control (stop has priority)
//     half_period[CNT_W]   system-clock cycles per clk_out phase (0 behaves as 1)
//     num_edges[BURST_W]   rising edges per burst (0 = free-running)
//     clk_out              generated clock
//     rise_pulse           one-cycle marker of each clk_out rising edge
//     busy, done           run status and one-cycle completion pulse
//     edges_left[BURST_W]  rising edges still to emit
//     state_dbg[2]         raw FSM state for observation only
//   Handshake: there is no valid/ready pair here. start is a level sampled on
//   every posedge while the generator is idle. stop is a level sampled on every
//   posedge. Neither input is acknowledged; busy reports acceptance.
interface clk_burst_if #(
  parameter int CNT_W   = 16,
  parameter int BURST_W = 8
);
  logic               start;
  logic               stop;
  logic [CNT_W-1:0]   half_period;
  logic [BURST_W-1:0] num_edges;
  logic               clk_out;
  logic               rise_pulse;
  logic               busy;
  logic               done;
  logic [BURST_W-1:0] edges_left;
  logic [1:0]         state_dbg;

  modport master (
    output start, stop, half_period, num_edges,
    input  clk_out, rise_pulse, busy, done, edges_left, state_dbg
  );

  modport slave (
    input  start, stop, half_period, num_edges,
    output clk_out, rise_pulse, busy, done, edges_left, state_dbg
  );
endinterface

// File: rtl/clk_burst_gen.sv
// clk_burst_gen: programmable clock-burst generator.
//   Divides the system clock into a 50% duty clk_out of period 2*hp cycles.
//   It emits either num_edges rising edges or runs freely until stop is seen.
//   Ports:
//     clk    system clock; all state updates on its rising edge
//     rst_n  asynchronous active-low reset
//     bus    clk_burst_if.slave; it carries run control in and clock/status out
//   Every output is a flop. busy is high from the start-accepting edge until
//   the cycle in which done pulses. done follows the DONE state by one cycle.
module clk_burst_gen #(
  parameter int CNT_W   = 16,
  parameter int BURST_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  clk_burst_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   hp_q, hp_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [BURST_W-1:0] edges_left_q, edges_left_d;
  logic               clk_out_q, clk_out_d;
  logic               rise_pulse_q, rise_pulse_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      hp_q         <= '0;
      burst_q      <= '0;
      edges_left_q <= '0;
      clk_out_q    <= 1'b0;
      rise_pulse_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hp_q         <= hp_d;
      burst_q      <= burst_d;
      edges_left_q <= edges_left_d;
      clk_out_q    <= clk_out_d;
      rise_pulse_q <= rise_pulse_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hp_d         = hp_q;
    burst_d      = burst_q;
    edges_left_d = edges_left_q;
    clk_out_d    = clk_out_q;
    rise_pulse_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.stop) begin
          hp_d         = (bus.half_period == '0) ? CNT_W'(1) : bus.half_period;
          burst_d      = bus.num_edges;
          edges_left_d = bus.num_edges;
          cnt_d        = '0;
          clk_out_d    = 1'b0;
          state_d      = ST_RUN;
        end
      end

      ST_RUN: begin
        if (bus.stop) begin
          clk_out_d    = 1'b0;
          cnt_d        = '0;
          edges_left_d = '0;
          state_d      = ST_IDLE;
        end else if (cnt_q == hp_q - CNT_W'(1)) begin
          cnt_d     = '0;
          clk_out_d = ~clk_out_q;
          if (!clk_out_q) begin
            rise_pulse_d = 1'b1;
            if (burst_q != '0 && edges_left_q != '0) begin
              edges_left_d = edges_left_q - BURST_W'(1);
            end
          end else if (burst_q != '0 && edges_left_q == '0) begin
            // The last counted rise has completed its high phase. The clock is
            // now low, so the burst can end without truncating a pulse.
            state_d = ST_DONE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // busy covers RUN and the DONE cycle. It drops in the same cycle that done rises.
  always_comb begin
    busy_d = (state_d != ST_IDLE);
    done_d = (state_q == ST_DONE);
  end

  assign bus.clk_out    = clk_out_q;
  assign bus.rise_pulse = rise_pulse_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.edges_left = edges_left_q;
  assign bus.state_dbg  = state_q;

endmodule
